// File: rtl/fifo_to_com_tx.sv
// Drains the shared FIFO into 8N1 UART frames (LSB first), then appends a CRC-8 (poly 0x07) trailer frame.
// Runs on the same clock as the COM-to-FIFO receive path.
module fifo_to_com_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_fifo_empty,
    input  logic       i_fifo_busy,
    input  logic [7:0] i_fifo_data,
    output logic       o_fifo_re,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_finish,
    output logic [7:0] o_crc,
    output logic [9:0] o_byte_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT,
        S_LOAD,
        S_LOAD_CRC,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    localparam logic [11:0] LP_LAST_CLK = 12'(CLKS_PER_BIT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [11:0] r_clk_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_is_crc;
    logic [7:0]  r_crc;
    logic [9:0]  r_byte_count;
    logic        w_bit_end;

    // Byte-wise CRC-8, MSB first, no reflection; caller XORs the new byte in first.
    function automatic logic [7:0] crc8(input logic [7:0] v);
        logic [7:0] c;
        c = v;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign w_bit_end = (r_clk_cnt == LP_LAST_CLK);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        o_fifo_re = 1'b0;
        o_tx      = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (i_fifo_empty) begin
                    w_next = S_LOAD_CRC;
                end else if (!i_fifo_busy) begin
                    o_fifo_re = 1'b1;
                    w_next    = S_WAIT;
                end
            end
            S_WAIT: begin
                w_next = S_LOAD;
            end
            S_LOAD, S_LOAD_CRC: begin
                w_next = S_START;
            end
            S_START: begin
                o_tx = 1'b0;
                if (w_bit_end) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                o_tx = r_shift[0];
                if (w_bit_end && (r_bit_cnt == 3'd7)) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_next = r_is_crc ? S_DONE : S_CHECK;
                end
            end
            S_DONE: begin
                if (!i_enable) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Bit timing counters return to zero at every bit boundary, so START always begins a fresh bit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_clk_cnt    <= 12'd0;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_is_crc     <= 1'b0;
            r_crc        <= 8'h00;
            r_byte_count <= 10'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        r_crc        <= 8'h00;
                        r_byte_count <= 10'd0;
                    end
                end
                S_LOAD: begin
                    r_shift      <= i_fifo_data;
                    r_crc        <= crc8(r_crc ^ i_fifo_data);
                    r_byte_count <= r_byte_count + 10'd1;
                    r_is_crc     <= 1'b0;
                end
                S_LOAD_CRC: begin
                    r_shift  <= r_crc;
                    r_is_crc <= 1'b1;
                end
                S_START, S_STOP: begin
                    r_clk_cnt <= w_bit_end ? 12'd0 : r_clk_cnt + 12'd1;
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= 12'd0;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 12'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_finish     = (r_state == S_DONE);
    assign o_crc        = r_crc;
    assign o_byte_count = r_byte_count;

endmodule
